// File: rtl/serial_adder_pkg.sv
// State encoding shared by the bit-serial arithmetic blocks.
package serial_adder_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_adder_full_adder.sv
// Single combinational full-adder cell; the only arithmetic in the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell, LSB first, N cycles per operation
// framed by a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         V
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  s_sh;
    logic [CW-1:0] count;
    logic          carry;
    logic          cout_r;
    logic          v_r;
    logic          sum_bit;
    logic          carry_next;
    logic          last_bit;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (sum_bit),
        .cout (carry_next)
    );

    assign last_bit = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = RUN;
            RUN:        if (last_bit) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Reset clears the datapath too so every output reads 0 right after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            count  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            v_r    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Cin;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= {sum_bit, s_sh[N-1:1]};
                    carry <= carry_next;
                    if (last_bit) begin
                        // carry still holds the carry into the MSB on this edge
                        cout_r <= carry_next;
                        v_r    <= carry ^ carry_next;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign S    = s_sh;
    assign Cout = cout_r;
    assign V    = v_r;
endmodule
